fifo_packet_scheduler: RTL
==========================

// Module: fifo_packet_scheduler
// PURPOSE
//  Round-robin scheduler that drains nOfFifos sample FIFOs into the UDP TX FIFO pair of Ethernet port 2.
//  Sits between the sample FIFOs and the eth_1gb_wrapper txfifo_1 interface, in the rx_xcvr_clk domain.
//  Each grant produces one UDP packet:
//  - header byte = FIFO index
//  - up to SAMPLES_PER_PACKET samples, MSB first
//  - the 96-bit status word last
// PARAMETERS
//  nOfFifos            7    number of sample FIFOs arbitrated (1..255)
//  FIFO_LENGTH         16   sample width in bits; multiple of 8, 8..64
//  SAMPLES_PER_PACKET  64   maximum samples per packet (1..255)
// PORTS
//  clk                 in   1                       125 MHz (rx_xcvr_clk)
//  reset_n             in   1                       asynchronous, active-low reset
//  enable              in   1                       permits new grants
//  destination_mac     in   48                      client MAC, sampled at grant
//  destination_ip      in   32                      client IP, sampled at grant; 0 = no client
//  rdreq_fifo          out  nOfFifos                one-hot read request
//  rddata_fifo         in   nOfFifos*FIFO_LENGTH    FIFO i occupies [i*FIFO_LENGTH +: FIFO_LENGTH]
//  rdempty_fifo        in   nOfFifos                empty flags
//  tx_fifo_data        out  8                       payload byte
//  tx_fifo_data_write  out  1                       payload write strobe
//  tx_fifo_data_full   in   1                       payload FIFO full
//  tx_fifo_status      out  96                      {mac[47:0], ip[31:0], byte_len[15:0]}
//  tx_fifo_status_write out 1                       status write strobe
//  tx_fifo_status_full in   1                       status FIFO full
//  busy                out  1                       high in any state except IDLE
//  packets_sent        out  32                      count of status words written; wraps
// BEHAVIOUR
//  - Reset: every output is 0; state IDLE; rr pointer 0; latched MAC/IP 0.
//  - Sample FIFOs are normal (non-show-ahead): data is valid on rddata_fifo the cycle after rdreq.
//  - rdreq is never asserted to an empty FIFO.
//  - States and transitions:
//    IDLE -> ARB when enable & destination_ip!=0 & !tx_fifo_status_full & |(~rdempty_fifo).
//    ARB (1 cycle): grant the first non-empty FIFO at or after rr_ptr, modulo nOfFifos.
//      Latch the index, MAC and IP; clear sample count; -> HDR.
//    HDR: when !tx_fifo_data_full, write the index byte; byte_len=1; -> RD.
//    RD: rdreq[g]=1 for exactly 1 cycle -> LATCH.
//    LATCH: capture rddata slice g into the shift register; count+=1 -> BYTES.
//    BYTES: write one byte per cycle when !tx_fifo_data_full, MSB first, FIFO_LENGTH/8 bytes;
//      byte_len increments with each byte. After the last byte:
//      -> RD if count<SAMPLES_PER_PACKET and !rdempty_fifo[g] (flag evaluated in that cycle);
//      -> STATUS otherwise.
//    STATUS: when !tx_fifo_status_full, pulse tx_fifo_status_write 1 cycle with the latched
//      {mac, ip, byte_len}; packets_sent+=1; rr_ptr=g+1 (wraps to 0 at nOfFifos); -> IDLE.
//  - byte_len = 1 + count*FIFO_LENGTH/8, at most 1+255*8 = 2041; fits in 16 bits.
//  - Data FIFO full: stall in HDR/BYTES with the write strobe low. No byte is dropped or duplicated.
//  - Status FIFO full at STATUS: wait there. Packet data already written stays in place.
//  - enable falling or destination_ip changing mid-packet: the current packet completes
//    with the latched values; no new grant is issued while enable=0.
//  - A FIFO emptying mid-packet: the packet closes early (minimum 1 sample); never 0 samples.
//  - Simultaneous requests: strict round-robin; a FIFO with continuous data cannot starve the others.
//  - Reset mid-packet: immediate return to IDLE. A partial payload may remain in the tx data FIFO;
//    the decoder reset flushes it, since both blocks share the MAC-configured reset.
//  - Latency: ARB to first data write = 2 cycles when not full. Steady state is
//    FIFO_LENGTH/8 + 2 cycles per sample.
// STRUCTURE
//  - Shared package/include, also used by new_dec_comm8_port2:
//    status-word field offsets (MAC 95:48, IP 47:16, LEN 15:0) and state encodings.
//  - One sub-module, rr_arbiter_onehot (nOfFifos): request vector + pointer -> one-hot grant + index.
//  - The byte serializer stays inline.
// TESTING
//  1. FIFO 3 holds 2 samples 0xABCD,0x1234 (defaults) -> bytes 03 AB CD 12 34;
//     status {mac, ip, 16'd5}; packets_sent=1.
//  2. All 7 FIFOs hold 200 samples -> grants go 0,1,..,6,0 in that order.
//     Each packet carries 64 samples, byte_len=129.
//  3. Hold tx_fifo_data_full for 10 cycles mid-BYTES -> the byte stream is unchanged,
//     with no write strobe while full.
//  4. destination_ip=0 or enable=0 with data present -> no rdreq and no writes.
//     Drop enable mid-packet -> the packet completes.
//  5. tx_fifo_status_full high at STATUS for 20 cycles -> exactly one status write after release.
//  6. Assert reset_n low mid-BYTES -> all outputs 0 within the same cycle;
//     after release, the next packet starts cleanly from FIFO 0.

Source files
------------

// File: rtl/fifo_packet_scheduler_pkg.sv
// rtl/fifo_packet_scheduler_pkg.sv - shared state encodings and status word layout
package fifo_packet_scheduler_pkg;

    localparam int STATE_W = 3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ARB    = 3'd1;
    localparam logic [2:0] ST_HDR    = 3'd2;
    localparam logic [2:0] ST_RD     = 3'd3;
    localparam logic [2:0] ST_LATCH  = 3'd4;
    localparam logic [2:0] ST_BYTES  = 3'd5;
    localparam logic [2:0] ST_STATUS = 3'd6;

    localparam int STATUS_W       = 96;
    localparam int STATUS_MAC_LSB = 48;
    localparam int STATUS_IP_LSB  = 16;
    localparam int STATUS_LEN_LSB = 0;

    // Status word consumed by the UDP TX path: {mac, ip, byte_len}
    function automatic logic [STATUS_W-1:0] pack_status(
        input logic [47:0] mac,
        input logic [31:0] ip,
        input logic [15:0] len
    );
        logic [STATUS_W-1:0] s;
        s = '0;
        s[STATUS_MAC_LSB +: 48] = mac;
        s[STATUS_IP_LSB +: 32]  = ip;
        s[STATUS_LEN_LSB +: 16] = len;
        return s;
    endfunction

endpackage

// File: rtl/fifo_packet_scheduler_rr_arbiter_onehot.sv
// rtl/fifo_packet_scheduler_rr_arbiter_onehot.sv - round-robin one-hot grant from request vector and pointer
module rr_arbiter_onehot #(
    parameter int N = 7
) (
    input  logic [N-1:0] req,
    input  logic [7:0]   ptr,
    output logic [N-1:0] grant,
    output logic [7:0]   index,
    output logic         valid
);

    // First pass searches ptr..N-1, second pass wraps to 0..ptr-1
    always_comb begin
        grant = '0;
        index = 8'd0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!valid && req[i] && (i >= int'(ptr))) begin
                grant[i] = 1'b1;
                index    = 8'(i);
                valid    = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!valid && req[i]) begin
                grant[i] = 1'b1;
                index    = 8'(i);
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_packet_scheduler.sv
// rtl/fifo_packet_scheduler.sv - round-robin drain of sample FIFOs into UDP TX data/status FIFOs
module fifo_packet_scheduler
    import fifo_packet_scheduler_pkg::*;
#(
    parameter int nOfFifos           = 7,
    parameter int FIFO_LENGTH        = 16,
    parameter int SAMPLES_PER_PACKET = 64
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            enable,
    input  logic [47:0]                     destination_mac,
    input  logic [31:0]                     destination_ip,
    output logic [nOfFifos-1:0]             rdreq_fifo,
    input  logic [nOfFifos*FIFO_LENGTH-1:0] rddata_fifo,
    input  logic [nOfFifos-1:0]             rdempty_fifo,
    output logic [7:0]                      tx_fifo_data,
    output logic                            tx_fifo_data_write,
    input  logic                            tx_fifo_data_full,
    output logic [95:0]                     tx_fifo_status,
    output logic                            tx_fifo_status_write,
    input  logic                            tx_fifo_status_full,
    output logic                            busy,
    output logic [31:0]                     packets_sent
);

    localparam int BYTES_PER_SAMPLE = FIFO_LENGTH / 8;

    logic [STATE_W-1:0]     state;
    logic [7:0]             rr_ptr;
    logic [7:0]             grant_idx;
    logic [nOfFifos-1:0]    grant_oh;
    logic [47:0]            mac_q;
    logic [31:0]            ip_q;
    logic [15:0]            byte_len;
    logic [7:0]             sample_cnt;
    logic [3:0]             byte_cnt;
    logic [FIFO_LENGTH-1:0] shreg;

    logic [nOfFifos-1:0]    arb_grant;
    logic [7:0]             arb_index;
    logic                   arb_valid;
    logic [FIFO_LENGTH-1:0] granted_data;
    logic                   granted_empty;
    logic                   last_byte;
    logic                   more_samples;

    rr_arbiter_onehot #(.N(nOfFifos)) u_arb (
        .req   (~rdempty_fifo),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .index (arb_index),
        .valid (arb_valid)
    );

    // Route the granted FIFO's data slice and empty flag
    always_comb begin
        granted_data  = '0;
        granted_empty = 1'b1;
        for (int i = 0; i < nOfFifos; i++) begin
            if (grant_oh[i]) begin
                granted_data  = rddata_fifo[i*FIFO_LENGTH +: FIFO_LENGTH];
                granted_empty = rdempty_fifo[i];
            end
        end
    end

    // Strobes are combinational on the full flags so a full cycle never loses a byte
    assign tx_fifo_data_write   = ((state == ST_HDR) || (state == ST_BYTES)) && !tx_fifo_data_full;
    assign tx_fifo_data         = (state == ST_HDR)   ? grant_idx :
                                  (state == ST_BYTES) ? shreg[FIFO_LENGTH-1 -: 8] : 8'h00;
    assign tx_fifo_status_write = (state == ST_STATUS) && !tx_fifo_status_full;
    assign tx_fifo_status       = pack_status(mac_q, ip_q, byte_len);
    assign rdreq_fifo           = (state == ST_RD) ? grant_oh : '0;
    assign busy                 = (state != ST_IDLE);
    assign last_byte            = (byte_cnt == 4'd1);
    assign more_samples         = (sample_cnt < 8'(SAMPLES_PER_PACKET)) && !granted_empty;

    // Packet FSM with inline MSB-first byte serializer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            rr_ptr       <= 8'd0;
            grant_idx    <= 8'd0;
            grant_oh     <= '0;
            mac_q        <= 48'd0;
            ip_q         <= 32'd0;
            byte_len     <= 16'd0;
            sample_cnt   <= 8'd0;
            byte_cnt     <= 4'd0;
            shreg        <= '0;
            packets_sent <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable && (destination_ip != 32'd0) && !tx_fifo_status_full && !(&rdempty_fifo))
                        state <= ST_ARB;
                end
                ST_ARB: begin
                    if (arb_valid) begin
                        grant_oh   <= arb_grant;
                        grant_idx  <= arb_index;
                        mac_q      <= destination_mac;
                        ip_q       <= destination_ip;
                        sample_cnt <= 8'd0;
                        byte_len   <= 16'd0;
                        state      <= ST_HDR;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_HDR: begin
                    if (!tx_fifo_data_full) begin
                        byte_len <= 16'd1;
                        state    <= ST_RD;
                    end
                end
                ST_RD: state <= ST_LATCH;
                ST_LATCH: begin
                    shreg      <= granted_data;
                    sample_cnt <= sample_cnt + 8'd1;
                    byte_cnt   <= 4'(BYTES_PER_SAMPLE);
                    state      <= ST_BYTES;
                end
                ST_BYTES: begin
                    if (!tx_fifo_data_full) begin
                        shreg    <= shreg << 8;
                        byte_len <= byte_len + 16'd1;
                        byte_cnt <= byte_cnt - 4'd1;
                        if (last_byte)
                            state <= more_samples ? ST_RD : ST_STATUS;
                    end
                end
                ST_STATUS: begin
                    if (!tx_fifo_status_full) begin
                        packets_sent <= packets_sent + 32'd1;
                        rr_ptr       <= (grant_idx == 8'(nOfFifos - 1)) ? 8'd0 : grant_idx + 8'd1;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
